// File: rtl/captura_adc_pkg.sv
// Shared constants and FSM encoding for the serial ADC capture block.
package captura_adc_pkg;

  // ADC code width, bits per serial frame and leading zero bits per frame.
  localparam int unsigned N_ADC      = 12;
  localparam int unsigned BITS_TRAMA = 16;
  localparam int unsigned BITS_CERO  = 4;

  // Width of the four-sample accumulator used by the optional averaging path.
  localparam int unsigned BITS_ACC = N_ADC + 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONVERSION = 2'd1,
    ENTREGA    = 2'd2
  } estado_e;

  // Place a code at the fixed-point position given by the fractional bit count.
  function automatic logic [31:0] alinear_codigo(logic [N_ADC-1:0] codigo, int unsigned frac);
    logic [31:0] ext;
    ext = 32'(codigo);
    return ext << frac;
  endfunction

endpackage

// File: rtl/captura_adc_if.sv
// Three-wire serial link between the capture block (master) and the ADC (slave).
interface captura_adc_if;

  logic sdata;
  logic cs_n;
  logic sclk;

  modport master (
    input  sdata,
    output cs_n,
    output sclk
  );

  modport slave (
    output sdata,
    input  cs_n,
    input  sclk
  );

endinterface

// File: rtl/divisor_sclk.sv
// Serial clock generator: sclk starts high, toggles every DIV clocks while enabled,
// and a registered strobe marks the first cycle of every sclk high phase.
module divisor_sclk #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic subida_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            subida_q, subida_d;

  // Half-period counter; disabled state parks sclk high with the counter cleared.
  always_comb begin
    cnt_d    = cnt_q;
    sclk_d   = sclk_q;
    subida_d = 1'b0;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (cnt_q == CntW'(DIV - 1)) begin
      cnt_d    = '0;
      sclk_d   = ~sclk_q;
      subida_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      sclk_q   <= 1'b1;
      subida_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sclk_q   <= sclk_d;
      subida_q <= subida_d;
    end
  end

  // Force idle-high whenever disabled so a late toggle never leaks out of a frame.
  assign sclk_o   = sclk_q | ~en_i;
  assign subida_o = subida_q;

endmodule

// File: rtl/captura_adc.sv
// Periodic serial ADC capture: every PERIODO clocks a 16-bit frame is clocked in,
// the 12-bit code is placed at y_k[Presicion+11:Presicion] and muestra_lista strobes.
// Optional feature macro: CAPTURA_ADC_PROMEDIO_EN (publish the mean of four frames).
module captura_adc
  import captura_adc_pkg::*;
#(
  parameter int unsigned Width     = 19,
  parameter int unsigned Presicion = 0,
  parameter int unsigned DIV       = 2,
  parameter int unsigned PERIODO   = 100
) (
  input  logic              clock,
  input  logic              reset,
  captura_adc_if.master     adc,
  output logic [Width-1:0]  y_k,
  output logic              muestra_lista,
  output logic              sobrecarga
);

  localparam int unsigned TimerW = (PERIODO > 1) ? $clog2(PERIODO) : 1;

  estado_e               estado_q, estado_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [BITS_TRAMA-1:0] trama_q, trama_d;
  logic [BITS_TRAMA-1:0] trama_sig;
  logic [Width-1:0]      y_q, y_d;
  logic                  lista_q, lista_d;
  logic                  sobre_q, sobre_d;
  logic                  tick;
  logic                  carga;
  logic                  en_div;
  logic                  sclk_w;
  logic                  subida;
  logic [N_ADC-1:0]      codigo;

  // Sample period timer; the last count is the tick.
  always_comb begin
    tick    = (timer_q == TimerW'(PERIODO - 1));
    timer_d = tick ? '0 : timer_q + TimerW'(1);
  end

  assign en_div = (estado_q == CONVERSION);

  divisor_sclk #(
    .DIV (DIV)
  ) u_divisor_sclk (
    .clk_i    (clock),
    .rst_i    (reset),
    .en_i     (en_div),
    .sclk_o   (sclk_w),
    .subida_o (subida)
  );

  // The frame register is seeded with a marker bit at frame start; once the
  // marker reaches the MSB the next rising edge delivers the 16th bit.
  assign trama_sig = {trama_q[BITS_TRAMA-2:0], adc.sdata};
  assign codigo    = trama_sig[N_ADC-1:0];

  // Next-state logic for the capture FSM, overrun flag and shift register.
  always_comb begin
    estado_d = estado_q;
    trama_d  = trama_q;
    sobre_d  = sobre_q;
    carga    = 1'b0;
    unique case (estado_q)
      IDLE: begin
        if (tick) begin
          estado_d = CONVERSION;
          trama_d  = BITS_TRAMA'(1);
        end
      end
      CONVERSION: begin
        if (tick) sobre_d = 1'b1;
        if (subida) begin
          trama_d = trama_sig;
          if (trama_q[BITS_TRAMA-1]) begin
            estado_d = ENTREGA;
            carga    = 1'b1;
          end
        end
      end
      ENTREGA: begin
        if (tick) sobre_d = 1'b1;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

`ifdef CAPTURA_ADC_PROMEDIO_EN
  logic [BITS_ACC-1:0] acc_q, acc_d;
  logic [1:0]          nconv_q, nconv_d;
  logic [BITS_ACC-1:0] suma;

  // Accumulate four codes; publish their mean on the fourth delivery.
  always_comb begin
    acc_d   = acc_q;
    nconv_d = nconv_q;
    y_d     = y_q;
    lista_d = 1'b0;
    suma    = acc_q + BITS_ACC'(codigo);
    if (carga) begin
      nconv_d = nconv_q + 2'd1;
      if (nconv_q == 2'd3) begin
        acc_d   = '0;
        y_d     = Width'(alinear_codigo(suma[BITS_ACC-1:2], Presicion));
        lista_d = 1'b1;
      end else begin
        acc_d = suma;
      end
    end
  end

  // Averaging state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      nconv_q <= '0;
    end else begin
      acc_q   <= acc_d;
      nconv_q <= nconv_d;
    end
  end
`else
  // Every completed frame is published directly.
  always_comb begin
    y_d     = y_q;
    lista_d = 1'b0;
    if (carga) begin
      y_d     = Width'(alinear_codigo(codigo, Presicion));
      lista_d = 1'b1;
    end
  end
`endif

  // Main state registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= IDLE;
      timer_q  <= '0;
      trama_q  <= '0;
      y_q      <= '0;
      lista_q  <= 1'b0;
      sobre_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      trama_q  <= trama_d;
      y_q      <= y_d;
      lista_q  <= lista_d;
      sobre_q  <= sobre_d;
    end
  end

  assign adc.cs_n      = ~en_div;
  assign adc.sclk      = sclk_w;
  assign y_k           = y_q;
  assign muestra_lista = lista_q;
  assign sobrecarga    = sobre_q;

endmodule

// File: tb/tb_captura_adc.sv
// Bench for captura_adc: two instances (defaults; Presicion=4 with PERIODO=60 to force
// overrun) checked every cycle against a timeline model derived from the frame rules.
module tb_captura_adc;

  localparam int unsigned DivC = 2;
  localparam int unsigned Wid  = 19;
  localparam int unsigned LenC = 32 * DivC;  // cycles from first cs_n low to last rise

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  captura_adc_if adc0 ();
  captura_adc_if adc1 ();

  logic [Wid-1:0] y_w[2];
  logic           ml_w[2];
  logic           sob_w[2];
  logic           cs_w[2];
  logic           sclk_w[2];
  logic           sd[2];

  captura_adc #(
    .Width     (Wid),
    .Presicion (0),
    .DIV       (DivC),
    .PERIODO   (100)
  ) u_dut0 (
    .clock         (clock),
    .reset         (reset),
    .adc           (adc0.master),
    .y_k           (y_w[0]),
    .muestra_lista (ml_w[0]),
    .sobrecarga    (sob_w[0])
  );

  captura_adc #(
    .Width     (Wid),
    .Presicion (4),
    .DIV       (DivC),
    .PERIODO   (60)
  ) u_dut1 (
    .clock         (clock),
    .reset         (reset),
    .adc           (adc1.master),
    .y_k           (y_w[1]),
    .muestra_lista (ml_w[1]),
    .sobrecarga    (sob_w[1])
  );

  assign cs_w[0]    = adc0.cs_n;
  assign cs_w[1]    = adc1.cs_n;
  assign sclk_w[0]  = adc0.sclk;
  assign sclk_w[1]  = adc1.sclk;
  assign adc0.sdata = sd[0];
  assign adc1.sdata = sd[1];

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int          per[2];
  int          prec[2];
  int          c;
  int          start[2];
  int          nfr[2];
  logic [15:0] frame[2];
  int          y_exp[2];
  logic        sob_exp[2];
  int          avg_n[2];
  int          avg_sum[2];
  int          falls[2];
  logic        prev_sclk[2];
  int          phase;
  int          rst_at2;

  function automatic logic [15:0] next_frame(int i, int n, int ph);
    logic [15:0] f;
    f = 16'($urandom_range(0, 4095));
    if ($urandom_range(0, 3) == 0) f[15:12] = 4'($urandom_range(1, 15));
    if (i == 0 && ph == 0 && n == 0) f = 16'h0ABC;
    if (i == 1 && ph == 0 && n == 0) f = 16'h0FFF;
    if (i == 0 && ph == 1 && n < 4) begin
      case (n)
        0: f = 16'd100;
        1: f = 16'd200;
        2: f = 16'd300;
        default: f = 16'd401;
      endcase
    end
    return f;
  endfunction

  task automatic model_reset();
    c = 0;
    for (int i = 0; i < 2; i++) begin
      start[i]   = -1000;
      nfr[i]     = 0;
      y_exp[i]   = 0;
      sob_exp[i] = 1'b0;
      avg_n[i]   = 0;
      avg_sum[i] = 0;
    end
  endtask

  initial begin
    per[0]  = 100;
    per[1]  = 60;
    prec[0] = 0;
    prec[1] = 4;
    sd[0]   = 1'b0;
    sd[1]   = 1'b0;
    phase   = 0;
    rst_at2 = 600 + int'($urandom_range(0, 200));
    for (int i = 0; i < 2; i++) begin
      falls[i]     = 0;
      prev_sclk[i] = 1'b1;
      frame[i]     = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    model_reset();

    for (int cyc = 0; cyc < 2200; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        int   off;
        logic in_conv;
        logic ml_exp;
        int   code;
        off     = c - start[i];
        in_conv = (start[i] >= 0) && (off >= 0) && (off <= int'(LenC));
        ml_exp  = 1'b0;
        if (start[i] >= 0 && off == int'(LenC) + 1) begin
          code = int'(frame[i][11:0]);
`ifdef CAPTURA_ADC_PROMEDIO_EN
          avg_sum[i] += code;
          avg_n[i]++;
          if (avg_n[i] == 4) begin
            y_exp[i]   = (avg_sum[i] / 4) << prec[i];
            ml_exp     = 1'b1;
            avg_n[i]   = 0;
            avg_sum[i] = 0;
          end
`else
          y_exp[i] = code << prec[i];
          ml_exp   = 1'b1;
`endif
        end
        check_eq($sformatf("cs_n%0d", i), 32'(cs_w[i]), 32'(!in_conv));
        check_eq($sformatf("sclk%0d", i), 32'(sclk_w[i]),
                 32'(in_conv ? ((off / int'(DivC)) % 2 == 0) : 1'b1));
        check_eq($sformatf("muestra%0d", i), 32'(ml_w[i]), 32'(ml_exp));
        check_eq($sformatf("y_k%0d", i), 32'(y_w[i]), 32'(y_exp[i]));
        check_eq($sformatf("sobre%0d", i), 32'(sob_w[i]), 32'(sob_exp[i]));

        // ADC: presents the MSB at cs_n fall, advances after each sclk fall past the first.
        if (cs_w[i]) begin
          falls[i]     = 0;
          prev_sclk[i] = 1'b1;
        end else begin
          if (prev_sclk[i] && !sclk_w[i]) falls[i]++;
          prev_sclk[i] = sclk_w[i];
        end
        begin
          int idx;
          idx = (falls[i] == 0) ? 15 : 16 - falls[i];
          if (idx < 0) idx = 0;
          sd[i] = frame[i][idx];
        end
      end

      reset = ((phase == 0) && (c == 329)) || ((phase == 1) && (c == rst_at2));
      @(posedge clock);
      if (reset) begin
        model_reset();
        phase++;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (c % per[i] == per[i] - 1) begin
            if (start[i] >= 0 && c <= start[i] + int'(LenC) + 1) begin
              sob_exp[i] = 1'b1;
            end else begin
              start[i] = c + 1;
              frame[i] = next_frame(i, nfr[i], phase);
              nfr[i]++;
            end
          end
        end
        c++;
      end
    end

    #1;
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/captura_adc.md
CAPTURA_ADC -- requirements
Module: captura_adc

Interface
REQ-001 Parameter Width, default 19, bit width of y_k; SHALL satisfy Width >= 13+Presicion.
REQ-002 Parameter Presicion, default 0, fractional bits of y_k; the ADC code SHALL be placed at y_k[Presicion+11:Presicion].
REQ-003 Parameter DIV, default 2, system clocks per SCLK half-period; SHALL be >= 1.
REQ-004 Parameter PERIODO, default 100, system clocks per sample period; SHALL be >= 32*DIV+4.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  input  1  system clock; every register updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 sdata  input  1  serial data from the ADC, MSB first.
REQ-009 cs_n  output  1  ADC chip select, active low.
REQ-010 sclk  output  1  ADC serial clock; idles high.
REQ-011 y_k  output  Width  latest sample, signed two's complement, always non-negative; registered.
REQ-012 muestra_lista  output  1  one-cycle strobe for the downstream controller's enable input.
REQ-013 sobrecarga  output  1  sticky overrun flag.

Function
REQ-014 The sample timer SHALL count 0..PERIODO-1 and wrap; the cycle in which it equals PERIODO-1 is the tick T.
REQ-015 FSM states SHALL be IDLE, CONVERSION and ENTREGA.
REQ-016 A tick in IDLE SHALL move the FSM to CONVERSION at T+1, with cs_n low from T+1.
REQ-017 In CONVERSION, sclk SHALL toggle every DIV clocks, starting high and falling first at T+1+DIV.
REQ-018 Rising edge k (k=1..16) SHALL occur at T+1+2*DIV*k, and sdata SHALL be shifted in on each rising edge.
REQ-019 After the 16th rising edge the FSM SHALL enter ENTREGA at T+2+32*DIV.
REQ-020 In ENTREGA, cs_n SHALL be high, y_k SHALL update and muestra_lista SHALL be high for exactly that one cycle.
REQ-021 The FSM SHALL return to IDLE on the cycle after ENTREGA.
REQ-022 Frame format: 16 bits, MSB first; bits 15:12 are leading zeros and are ignored; bits 11:0 are the code.
REQ-023 y_k SHALL equal the zero-extended code shifted left by Presicion; the upper bits, including the sign bit, SHALL be 0.
REQ-024 A tick in CONVERSION or ENTREGA SHALL be ignored, SHALL NOT restart the frame, and SHALL set sobrecarga.
REQ-025 sobrecarga SHALL clear only on reset.
REQ-026 y_k SHALL hold its value between ENTREGA cycles.

Reset
REQ-027 Reset in any state SHALL, on the next clock edge, give: FSM=IDLE, timer=0, shift register=0, cs_n=1, sclk=1, y_k=0, muestra_lista=0, sobrecarga=0.
REQ-028 Reset during CONVERSION SHALL abort the frame with no partial y_k update and no muestra_lista pulse.

Configuration
REQ-029 The macro CAPTURA_ADC_PROMEDIO_EN SHALL select averaging.
REQ-030 With CAPTURA_ADC_PROMEDIO_EN defined, four consecutive codes SHALL be accumulated in 14 bits.
REQ-031 With it defined, y_k SHALL update to (sum>>2)<<Presicion, and muestra_lista SHALL pulse, only on every 4th ENTREGA.
REQ-032 With it defined, reset SHALL clear the accumulator and the 2-bit conversion counter.
REQ-033 Without CAPTURA_ADC_PROMEDIO_EN, every ENTREGA SHALL update y_k and pulse muestra_lista.

Structure
REQ-034 Shared package captura_adc_pkg SHALL hold N_ADC=12, BITS_TRAMA=16, BITS_CERO=4 and the FSM state encoding.
REQ-035 Sub-module divisor_sclk SHALL generate the sclk level and a one-cycle rising-edge strobe from DIV, enabled only in CONVERSION.

Verification
REQ-036 DIV=2, PERIODO=100, sdata frame 0000_1010_1011_1100 -> y_k=19'h00ABC and muestra_lista high only at T+66.
REQ-037 Frame 0000_1111_1111_1111 with Presicion=4 -> y_k=19'h0FFF0, y_k[18]=0.
REQ-038 Reset asserted at T+30 mid-frame -> next cycle cs_n=1, sclk=1, y_k=0; no muestra_lista until the next tick T'+66.
REQ-039 Force PERIODO=60 (< 32*DIV+4) -> sobrecarga=1 after the second tick, the frame still completes, and the flag stays 1 until reset.
REQ-040 With CAPTURA_ADC_PROMEDIO_EN, codes 100,200,300,401 -> a single muestra_lista after the 4th frame, with y_k=250.
REQ-041 Count sclk rising edges per cs_n low window -> exactly 16, and cs_n low for exactly 32*DIV+1 cycles.
